// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle instruction sequencer:
// FSM state encoding, opcode values and SIGNAL control-word bit positions.
package multicycle_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'b00;
  localparam opcode_t OP_LW  = 2'b01;
  localparam opcode_t OP_SW  = 2'b10;
  localparam opcode_t OP_JMP = 2'b11;

  localparam int SIG_REGDST   = 7;
  localparam int SIG_REGWRITE = 6;
  localparam int SIG_ALUSRC   = 5;
  localparam int SIG_JMP      = 4;
  localparam int SIG_MEMREAD  = 3;
  localparam int SIG_MEMWRITE = 2;
  localparam int SIG_MEMTOREG = 1;
  localparam int SIG_ALUOP    = 0;

  // Opcode-only control bits; phase-dependent bits are added by the sequencer.
  typedef struct packed {
    logic regdst;
    logic alusrc;
    logic jmp;
    logic memtoreg;
    logic aluop;
  } static_ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder producing the static (phase-independent)
// control bits for the multicycle sequencer.
module seq_decode
  import multicycle_pkg::*;
(
  input  opcode_t      i_opcode,
  output static_ctrl_t o_ctrl
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_ctrl = '0;
    case (i_opcode)
      OP_ADD: o_ctrl.regdst = 1'b1;
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memtoreg = 1'b1;
      end
      OP_SW:  o_ctrl.alusrc = 1'b1;
      OP_JMP: o_ctrl.jmp    = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retired-instruction count.
// Optional macro SINGLE_STEP_EN adds a STEP input and returns to IDLE after every instruction.
module multicycle_sequencer
  import multicycle_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] INSTR,
  input  logic       INSTR_VALID,
  output logic       INSTR_READY,
  input  logic       HALT,
`ifdef SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic [7:0] IR,
  output logic [7:0] SIGNAL,
  output logic       PC_EN,
  output logic       BUSY,
  output logic [7:0] INSTR_CNT
);

  state_t       r_state;
  state_t       w_state_nxt;
  state_t       w_after_final;
  logic [7:0]   r_ir;
  logic [7:0]   r_cnt;
  logic         r_armed;
  opcode_t      w_op;
  static_ctrl_t w_ctrl;
  logic         w_final;
  logic         w_start;
  logic [7:0]   w_signal;

  assign w_op = r_ir[7:6];

  seq_decode u_decode (
    .i_opcode (w_op),
    .o_ctrl   (w_ctrl)
  );

  // r_armed delays the first IDLE->FETCH until the second edge after reset release.
`ifdef SINGLE_STEP_EN
  assign w_start       = r_armed && !HALT && STEP;
  assign w_after_final = IDLE;
`else
  assign w_start       = r_armed && !HALT;
  assign w_after_final = HALT ? IDLE : FETCH;
`endif

  assign w_final = ((r_state == EXEC) && (w_op == OP_JMP)) ||
                   ((r_state == MEM)  && (w_op == OP_SW))  ||
                   (r_state == WB);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (w_start) w_state_nxt = FETCH;
      FETCH:  if (INSTR_VALID) w_state_nxt = DECODE;
      DECODE: w_state_nxt = EXEC;
      EXEC: begin
        case (w_op)
          OP_ADD:       w_state_nxt = WB;
          OP_LW, OP_SW: w_state_nxt = MEM;
          default:      w_state_nxt = w_after_final;
        endcase
      end
      MEM:    w_state_nxt = (w_op == OP_LW) ? WB : w_after_final;
      WB:     w_state_nxt = w_after_final;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_armed <= 1'b1;
      if ((r_state == FETCH) && INSTR_VALID) r_ir <= INSTR;
      if (w_final) r_cnt <= r_cnt + 8'd1;
    end
  end

  // MEMTOREG only steers the writeback mux, so it is shown in WB alone.
  always_comb begin
    w_signal = '0;
    if ((r_state == EXEC) || (r_state == MEM) || (r_state == WB)) begin
      w_signal[SIG_REGDST]   = w_ctrl.regdst;
      w_signal[SIG_ALUSRC]   = w_ctrl.alusrc;
      w_signal[SIG_JMP]      = w_ctrl.jmp;
      w_signal[SIG_ALUOP]    = w_ctrl.aluop;
      w_signal[SIG_MEMREAD]  = (r_state == MEM) && (w_op == OP_LW);
      w_signal[SIG_MEMWRITE] = (r_state == MEM) && (w_op == OP_SW);
      w_signal[SIG_MEMTOREG] = (r_state == WB) && w_ctrl.memtoreg;
      w_signal[SIG_REGWRITE] = (r_state == WB);
    end
  end

  assign SIGNAL      = w_signal;
  assign PC_EN       = w_final;
  assign INSTR_READY = (r_state == FETCH);
  assign BUSY        = (r_state != IDLE);
  assign IR          = r_ir;
  assign INSTR_CNT   = r_cnt;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: stimulus queues the expected
// per-cycle control words, a negedge monitor pops and compares them.
module tb_multicycle_sequencer;

  logic       CLK;
  logic       RST;
  logic [7:0] INSTR;
  logic       INSTR_VALID;
  logic       INSTR_READY;
  logic       HALT;
  logic [7:0] IR;
  logic [7:0] SIGNAL;
  logic       PC_EN;
  logic       BUSY;
  logic [7:0] INSTR_CNT;
`ifdef SINGLE_STEP_EN
  logic       STEP;
  initial STEP = 1'b1;
`endif

  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] sig;
    logic       pc_en;
  } exp_t;

  exp_t       exp_q[$];
  int         tests_run;
  int         tests_failed;
  logic [7:0] exp_cnt;

  multicycle_sequencer dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .HALT        (HALT),
`ifdef SINGLE_STEP_EN
    .STEP        (STEP),
`endif
    .IR          (IR),
    .SIGNAL      (SIGNAL),
    .PC_EN       (PC_EN),
    .BUSY        (BUSY),
    .INSTR_CNT   (INSTR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] ir, input logic [7:0] sig, input logic pc);
    exp_t e;
    e.ir = ir; e.sig = sig; e.pc_en = pc;
    exp_q.push_back(e);
  endtask

  // Expected DECODE..final control words per opcode.
  task automatic push_exp(input logic [7:0] instr);
    case (instr[7:6])
      2'b00: begin push(instr, 8'h00, 0); push(instr, 8'h80, 0); push(instr, 8'hC0, 1); end
      2'b01: begin push(instr, 8'h00, 0); push(instr, 8'h20, 0); push(instr, 8'h28, 0); push(instr, 8'h62, 1); end
      2'b10: begin push(instr, 8'h00, 0); push(instr, 8'h20, 0); push(instr, 8'h24, 1); end
      default: begin push(instr, 8'h00, 0); push(instr, 8'h10, 1); end
    endcase
  endtask

  // Called with the DUT in FETCH; returns after the final state, in FETCH or IDLE.
  task automatic do_instr(input logic [7:0] instr, input int exp_cycles, input bit halt_in_exec);
    int n;
    bit done;
    n = 0;
    done = 0;
    INSTR = instr;
    INSTR_VALID = 1'b1;
    push_exp(instr);
    while (!done && n < 20) begin
      tick();
      n++;
      if (n == 1) begin
        INSTR = instr ^ 8'hFF;
        INSTR_VALID = 1'b0;
      end
      if (n == 2 && halt_in_exec) HALT = 1'b1;
      if (PC_EN === 1'b1) done = 1;
    end
    check("pc_en_seen", 32'(done), 32'd1);
    tick();
    n++;
    check("cycles_per_instr", n, exp_cycles);
    exp_cnt = exp_cnt + 8'd1;
    check("instr_cnt", INSTR_CNT, exp_cnt);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    tick();
    check("post_reset_ready", INSTR_READY, 1'b0);
    check("post_reset_busy", BUSY, 1'b0);
    tick();
    check("first_fetch_ready", INSTR_READY, 1'b1);
    check("first_fetch_busy", BUSY, 1'b1);
  endtask

  always @(negedge CLK) begin
    if (BUSY === 1'b1 && INSTR_READY === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {SIGNAL, 7'd0, PC_EN}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("seq_signal", SIGNAL, e.sig);
        check("seq_pc_en", PC_EN, e.pc_en);
        check("seq_ir", IR, e.ir);
      end
    end else begin
      check("quiet_signal", SIGNAL, 8'h00);
      check("quiet_pc_en", PC_EN, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_cnt = 8'h00;
    RST = 1'b0;
    HALT = 1'b0;
    INSTR = 8'h00;
    INSTR_VALID = 1'b0;

    #23;
    check("rst_ir", IR, 8'h00);
    check("rst_signal", SIGNAL, 8'h00);
    check("rst_pc_en", PC_EN, 1'b0);
    check("rst_ready", INSTR_READY, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_cnt", INSTR_CNT, 8'h00);
    release_reset();

    for (int i = 0; i < 3; i++) do_instr(8'h1B, 4, 0);
    for (int i = 0; i < 2; i++) do_instr(8'h45, 5, 0);
    do_instr(8'h86, 4, 0);
    check("sw_then_fetch", INSTR_READY, 1'b1);
    do_instr(8'hC1, 3, 0);

    // Stall in FETCH with garbage on INSTR and no valid.
    INSTR_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      INSTR = 8'hA5 + 8'(i);
      tick();
      check("stall_ready", INSTR_READY, 1'b1);
      check("stall_busy", BUSY, 1'b1);
      check("stall_signal", SIGNAL, 8'h00);
      check("stall_ir", IR, 8'hC1);
    end

    // 256 JMPs from count 7: wraps through 255->0 on the 249th, ends back at 7.
    for (int i = 0; i < 256; i++) begin
      do_instr(8'hC1, 3, 0);
      if (i == 248) check("cnt_wrap_zero", INSTR_CNT, 8'h00);
    end
    check("cnt_after_256_jmp", INSTR_CNT, 8'h07);

    do_instr(8'h1B, 4, 1);
    check("halt_idle_busy", BUSY, 1'b0);
    check("halt_idle_ready", INSTR_READY, 1'b0);
    tick();
    tick();
    check("halt_hold_busy", BUSY, 1'b0);
    HALT = 1'b0;
    tick();
    check("resume_fetch", INSTR_READY, 1'b1);

    // Reset asserted while an LW sits in MEM.
    INSTR = 8'h45;
    INSTR_VALID = 1'b1;
    push(8'h45, 8'h00, 0);
    push(8'h45, 8'h20, 0);
    tick();
    INSTR_VALID = 1'b0;
    tick();
    tick();
    check("lw_mem_signal", SIGNAL, 8'h28);
    RST = 1'b0;
    #1;
    check("midrst_signal", SIGNAL, 8'h00);
    check("midrst_pc_en", PC_EN, 1'b0);
    check("midrst_cnt", INSTR_CNT, 8'h00);
    check("midrst_busy", BUSY, 1'b0);
    check("midrst_ir", IR, 8'h00);
    check("midrst_ready", INSTR_READY, 1'b0);
    exp_cnt = 8'h00;
    tick();
    release_reset();
    do_instr(8'h1B, 4, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
